// File: rtl/wb_warmboot_ctrl.sv
// Wishbone-mapped warm-boot controller: image select, programmable boot delay and
// an optional watchdog that forces a fallback image.
module wb_warmboot_ctrl #(
  parameter int              SEL_W   = 2,
  parameter int              DELAY_W = 24,
  parameter logic [SEL_W-1:0] WDT_SEL = '0,
  parameter int              DW      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       wb_addr,
  output logic [DW-1:0]    wb_rdata,
  input  logic [DW-1:0]    wb_wdata,
  input  logic             wb_we,
  input  logic             wb_cyc,
  output logic             wb_ack,
  output logic             boot_now,
  output logic [SEL_W-1:0] boot_sel,
  output logic             wdt_fired
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    FIRE  = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [DELAY_W-1:0] cnt_reg, cnt_next;
  logic [DELAY_W-1:0] delay_reg;
  logic [DELAY_W-1:0] wdt_cnt_reg;
  logic [SEL_W-1:0]   sel_pending_reg;
  logic [SEL_W-1:0]   sel_latched_reg;
  logic               wdt_en_reg;
  logic               wdt_fired_reg;
  logic               ack_reg;
  logic [DW-1:0]      rdata_mux;

  logic wr, wr_ctrl, wr_delay, wr_wdt, go, cancel, wdt_expire;
  logic unused_wdata;

  assign unused_wdata = ^wb_wdata;

  // Writes take effect on the edge that closes the ack cycle; FIRE ignores them.
  assign wr         = wb_cyc & wb_we & ack_reg & (state_reg != FIRE);
  assign wr_ctrl    = wr & (wb_addr == 2'd0);
  assign wr_delay   = wr & (wb_addr == 2'd1);
  assign wr_wdt     = wr & (wb_addr == 2'd2);
  assign cancel     = wr_ctrl & wb_wdata[9];
  assign go         = wr_ctrl & wb_wdata[8] & ~wb_wdata[9];
  // Any watchdog write (kick or disable) on the 1->0 edge pre-empts expiry.
  assign wdt_expire = wdt_en_reg & (state_reg != FIRE) &
                      (wdt_cnt_reg == DELAY_W'(1)) & ~wr_wdt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // FIRE is reached delay_reg edges after the GO commit edge.
  always_comb begin
    state_next = state_reg;
    cnt_next   = (cnt_reg != '0) ? cnt_reg - DELAY_W'(1) : '0;
    unique case (state_reg)
      IDLE, COUNT: begin
        if (cancel) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (go) begin
          if (delay_reg == '0) begin
            state_next = FIRE;
          end else begin
            state_next = COUNT;
            cnt_next   = delay_reg;
          end
        end else if (state_reg == COUNT && cnt_reg == DELAY_W'(1)) begin
          state_next = FIRE;
        end
      end
      default: state_next = FIRE;
    endcase
    if (wdt_expire) state_next = FIRE;
  end

  always_comb begin
    boot_now  = (state_reg == FIRE);
    boot_sel  = '0;
    wdt_fired = wdt_fired_reg;
    if (state_reg == FIRE) boot_sel = wdt_fired_reg ? WDT_SEL : sel_latched_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_reg         <= 1'b0;
      delay_reg       <= '0;
      wdt_cnt_reg     <= '0;
      sel_pending_reg <= '0;
      sel_latched_reg <= '0;
      wdt_en_reg      <= 1'b0;
      wdt_fired_reg   <= 1'b0;
    end else begin
      ack_reg <= wb_cyc & ~ack_reg;
      if (wr_ctrl)  sel_pending_reg <= wb_wdata[SEL_W-1:0];
      if (go)       sel_latched_reg <= wb_wdata[SEL_W-1:0];
      if (wr_delay) delay_reg       <= wb_wdata[DELAY_W-1:0];
      if (wr_wdt) begin
        wdt_en_reg  <= wb_wdata[0];
        wdt_cnt_reg <= {DELAY_W{wb_wdata[0]}};
      end else if (wdt_en_reg && state_reg != FIRE && wdt_cnt_reg != '0) begin
        wdt_cnt_reg <= wdt_cnt_reg - DELAY_W'(1);
      end
      if (wdt_expire) wdt_fired_reg <= 1'b1;
    end
  end

  always_comb begin
    rdata_mux = '0;
    unique case (wb_addr)
      2'd0: rdata_mux[SEL_W-1:0]   = sel_pending_reg;
      2'd1: rdata_mux[DELAY_W-1:0] = delay_reg;
      2'd2: rdata_mux[0]           = wdt_en_reg;
      default: begin
        rdata_mux[1:0]       = state_reg;
        rdata_mux[2]         = wdt_en_reg;
        rdata_mux[3]         = wdt_fired_reg;
        rdata_mux[8 +: SEL_W] = sel_pending_reg;
      end
    endcase
  end

  assign wb_ack   = ack_reg;
  assign wb_rdata = ack_reg ? rdata_mux : '0;

endmodule

// File: tb/tb_wb_warmboot_ctrl.sv
// Directed bench for wb_warmboot_ctrl: register table plus timed delay/watchdog sequences.
module tb_wb_warmboot_ctrl;

  localparam int SEL_W   = 2;
  localparam int DELAY_W = 8;
  localparam int DW      = 32;
  localparam logic [SEL_W-1:0] WDT_SEL = 2'd3;

  localparam logic [1:0] A_CTRL = 2'd0, A_DELAY = 2'd1, A_WDT = 2'd2, A_STAT = 2'd3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       wb_addr = '0;
  logic [DW-1:0]    wb_rdata;
  logic [DW-1:0]    wb_wdata = '0;
  logic             wb_we = 1'b0;
  logic             wb_cyc = 1'b0;
  logic             wb_ack;
  logic             boot_now;
  logic [SEL_W-1:0] boot_sel;
  logic             wdt_fired;

  int n_vec = 0;
  int n_bad = 0;
  int edge_cnt = 0;
  int last_commit = 0;

  wb_warmboot_ctrl #(
    .SEL_W(SEL_W), .DELAY_W(DELAY_W), .WDT_SEL(WDT_SEL), .DW(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wb_addr(wb_addr), .wb_rdata(wb_rdata),
    .wb_wdata(wb_wdata), .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(wb_ack),
    .boot_now(boot_now), .boot_sel(boot_sel), .wdt_fired(wdt_fired)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got %0d edges required fewer", edge_cnt);
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [1:0]  addr;
    logic        we;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int e);
    while (edge_cnt < e) tick;
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
    wb_addr = a; wb_wdata = d; wb_we = 1'b1; wb_cyc = 1'b1;
    tick;
    check("wr_ack", 32'(wb_ack), 32'd1);
    tick;
    last_commit = edge_cnt;
    check("wr_ack_single", 32'(wb_ack), 32'd0);
    wb_cyc = 1'b0; wb_we = 1'b0;
    $display("wr addr=%0d data=0x%0h commit_edge=%0d", a, d, last_commit);
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
    wb_addr = a; wb_we = 1'b0; wb_cyc = 1'b1;
    tick;
    check("rd_ack", 32'(wb_ack), 32'd1);
    d = wb_rdata;
    tick;
    check("rd_idle_zero", wb_rdata, 32'd0);
    wb_cyc = 1'b0;
    $display("rd addr=%0d data=0x%0h", a, d);
  endtask

  task automatic do_reset;
    rst_n = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
    repeat (5) tick;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] rd;
    int e, seen;

    tbl[0]  = '{A_STAT,  1'b0, 32'h0,         32'h0};
    tbl[1]  = '{A_DELAY, 1'b1, 32'h00ABCD12,  32'h0};
    tbl[2]  = '{A_DELAY, 1'b0, 32'h0,         32'h12};
    tbl[3]  = '{A_CTRL,  1'b1, 32'hFFFFF0F1,  32'h0};
    tbl[4]  = '{A_CTRL,  1'b0, 32'h0,         32'h1};
    tbl[5]  = '{A_CTRL,  1'b1, 32'h3,         32'h0};
    tbl[6]  = '{A_CTRL,  1'b0, 32'h0,         32'h3};
    tbl[7]  = '{A_STAT,  1'b0, 32'h0,         32'h0300};
    tbl[8]  = '{A_WDT,   1'b1, 32'h1,         32'h0};
    tbl[9]  = '{A_WDT,   1'b0, 32'h0,         32'h1};
    tbl[10] = '{A_STAT,  1'b0, 32'h0,         32'h0304};
    tbl[11] = '{A_WDT,   1'b1, 32'h0,         32'h0};
    tbl[12] = '{A_STAT,  1'b0, 32'h0,         32'h0300};
    tbl[13] = '{A_CTRL,  1'b1, 32'h302,       32'h0};
    tbl[14] = '{A_STAT,  1'b0, 32'h0,         32'h0200};
    tbl[15] = '{A_DELAY, 1'b1, 32'h0,         32'h0};
    tbl[16] = '{A_DELAY, 1'b0, 32'h0,         32'h0};

    // Reset state
    do_reset;
    check("rst_boot_now", 32'(boot_now), 32'd0);
    check("rst_boot_sel", 32'(boot_sel), 32'd0);
    check("rst_ack", 32'(wb_ack), 32'd0);
    check("rst_wdt_fired", 32'(wdt_fired), 32'd0);

    // Register table
    for (int i = 0; i < 17; i++) begin
      if (tbl[i].we) begin
        wb_write(tbl[i].addr, tbl[i].data);
      end else begin
        wb_read(tbl[i].addr, rd);
        check($sformatf("tbl%0d", i), rd, tbl[i].exp);
      end
    end

    // Zero delay: fire the cycle after the ack cycle, then terminal
    check("d0_pre", 32'(boot_now), 32'd0);
    wb_write(A_CTRL, 32'h102);
    check("d0_boot_now", 32'(boot_now), 32'd1);
    check("d0_boot_sel", 32'(boot_sel), 32'd2);
    check("d0_wdt_fired", 32'(wdt_fired), 32'd0);
    wb_read(A_STAT, rd);
    check("d0_status", rd, 32'h0202);
    wb_write(A_CTRL, 32'h101);
    wb_write(A_DELAY, 32'h5);
    check("fire_sel_hold", 32'(boot_sel), 32'd2);
    wb_read(A_CTRL, rd);
    check("fire_ctrl_hold", rd, 32'h2);
    wb_read(A_DELAY, rd);
    check("fire_delay_hold", rd, 32'h0);
    rst_n = 1'b0;
    tick;
    check("rst_from_fire", 32'(boot_now), 32'd0);
    do_reset;

    // Delay 10
    wb_write(A_DELAY, 32'd10);
    wb_write(A_CTRL, 32'h101);
    e = last_commit;
    wb_read(A_STAT, rd);
    check("d10_status_count", rd, 32'h0101);
    wait_until(e + 9);
    check("d10_early", 32'(boot_now), 32'd0);
    tick;
    check("d10_fire", 32'(boot_now), 32'd1);
    check("d10_sel", 32'(boot_sel), 32'd1);
    check("d10_no_wdt", 32'(wdt_fired), 32'd0);
    do_reset;

    // GO during COUNT restarts with new sel
    wb_write(A_DELAY, 32'd30);
    wb_write(A_CTRL, 32'h101);
    e = last_commit;
    wait_until(e + 8);
    wb_write(A_CTRL, 32'h102);
    wait_until(e + 30);
    check("restart_old_deadline", 32'(boot_now), 32'd0);
    wait_until(last_commit + 29);
    check("restart_early", 32'(boot_now), 32'd0);
    tick;
    check("restart_fire", 32'(boot_now), 32'd1);
    check("restart_sel", 32'(boot_sel), 32'd2);
    do_reset;

    // CANCEL after 20 cycles
    wb_write(A_DELAY, 32'd100);
    wb_write(A_CTRL, 32'h101);
    e = last_commit;
    wait_until(e + 18);
    wb_write(A_CTRL, 32'h200);
    wb_read(A_STAT, rd);
    check("cancel_status", rd, 32'h0);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      tick;
      if (boot_now) seen++;
    end
    check("cancel_hold", 32'(seen), 32'd0);
    do_reset;

    // Watchdog expiry with no kick
    wb_write(A_WDT, 32'h1);
    e = last_commit;
    wait_until(e + 254);
    check("wdt_early", 32'(boot_now), 32'd0);
    tick;
    check("wdt_fire", 32'(boot_now), 32'd1);
    check("wdt_sel", 32'(boot_sel), 32'(WDT_SEL));
    check("wdt_fired", 32'(wdt_fired), 32'd1);
    wb_read(A_STAT, rd);
    check("wdt_status", rd, 32'h000E);
    do_reset;

    // Periodic kicks, then disable
    wb_write(A_WDT, 32'h1);
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      e = last_commit;
      while (edge_cnt < e + 98) begin
        tick;
        if (boot_now) seen++;
      end
      wb_write(A_WDT, 32'h3);
    end
    check("kick_no_fire", 32'(seen), 32'd0);
    wb_read(A_STAT, rd);
    check("kick_status", rd, 32'h0004);
    wb_write(A_WDT, 32'h0);
    for (int i = 0; i < 300; i++) begin
      tick;
      if (boot_now) seen++;
    end
    check("wdt_disabled_hold", 32'(seen), 32'd0);
    do_reset;

    // Kick exactly on the 1->0 edge, then full reload period
    wb_write(A_WDT, 32'h1);
    e = last_commit;
    wait_until(e + 253);
    wb_write(A_WDT, 32'h3);
    check("kick_edge_commit", 32'(last_commit), 32'(e + 255));
    check("kick_edge_no_fire", 32'(boot_now), 32'd0);
    check("kick_edge_no_wdt", 32'(wdt_fired), 32'd0);
    e = last_commit;
    wait_until(e + 254);
    check("reload_early", 32'(boot_now), 32'd0);
    tick;
    check("reload_fire", 32'(boot_now), 32'd1);
    do_reset;

    // COUNT terminal coincides with watchdog expiry
    wb_write(A_DELAY, 32'd50);
    wb_write(A_WDT, 32'h1);
    e = last_commit;
    wait_until(e + 203);
    wb_write(A_CTRL, 32'h101);
    wait_until(e + 254);
    check("coinc_early", 32'(boot_now), 32'd0);
    tick;
    check("coinc_fire", 32'(boot_now), 32'd1);
    check("coinc_sel", 32'(boot_sel), 32'(WDT_SEL));
    check("coinc_wdt_fired", 32'(wdt_fired), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
